// File: rtl/digit_serial_adder_pkg.sv
// rtl/digit_serial_adder_pkg.sv - shared types and sizing for the digit-serial adder
package digit_serial_adder_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DIGIT_DEF = 4;

  function automatic int cnt_width(input int ndig);
    int w;
    w = $clog2(ndig);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int NDIG  = WIDTH_DEF / DIGIT_DEF;
  localparam int CNT_W = cnt_width(NDIG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/digit_rca.sv
// rtl/digit_rca.sv - combinational DIGIT-bit ripple chain of full-adder cells
module digit_rca #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             c_in,
  output logic [DIGIT-1:0] s,
  output logic             c_out,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .c_in (c[i]),
      .s    (s[i]),
      .c_out(c[i+1])
    );
  end

  assign c_out = c[DIGIT];
  // Carry into the top bit of this digit; only meaningful for the last digit's ovf.
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full-adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - WIDTH-bit add/subtract, DIGIT bits per clock with start/busy/done
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int ND = WIDTH / DIGIT;
  localparam int CW = cnt_width(ND);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  int unsigned      dig_lsb;
  logic [DIGIT-1:0] a_dig, b_dig, rca_s;
  logic             rca_co, rca_cmsb;
  logic             last_dig;

  assign dig_lsb  = 32'(cnt_q) * DIGIT;
  assign a_dig    = a_q[dig_lsb +: DIGIT];
  assign b_dig    = b_q[dig_lsb +: DIGIT];
  assign last_dig = (cnt_q == CW'(ND - 1));

  digit_rca #(.DIGIT(DIGIT)) u_rca (
    .a    (a_dig),
    .b    (b_dig),
    .c_in (carry_q),
    .s    (rca_s),
    .c_out(rca_co),
    .c_msb(rca_cmsb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B once here and seed the carry with 1.
          state_d = RUN;
          cnt_d   = '0;
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub | c_in;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        part_d[dig_lsb +: DIGIT] = rca_s;
        carry_d = rca_co;
        cnt_d   = cnt_q + 1'b1;
        if (last_dig) begin
          state_d = DONE;
          done_d  = 1'b1;
          sum_d   = part_d;
          c_out_d = rca_co;
          ovf_d   = rca_cmsb ^ rca_co;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - scoreboard bench for digit_serial_adder (WIDTH=16, DIGIT=4)
module tb_digit_serial_adder;

  localparam int W = 16;
  localparam int N = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         busy, done, c_out, ovf;
  logic [W-1:0] sum;

  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  exp_t         sb[$];
  exp_t         mon_e;
  logic [W-1:0] last_sum = '0;

  digit_serial_adder #(.WIDTH(W), .DIGIT(W/N)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .c_in (c_in),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .c_out(c_out),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: whole-word arithmetic, overflow from operand/result signs.
  function automatic exp_t model(input bit s, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input bit ci);
    exp_t e;
    logic [W:0] full;
    if (!s) full = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
    else    full = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    e.sum   = full[W-1:0];
    e.c_out = full[W];
    if (!s) e.ovf = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
    else    e.ovf = (x[W-1] != y[W-1]) && (e.sum[W-1] != x[W-1]);
    e.cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      last_sum = '0;
    end else if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sum", 32'(sum), 32'(mon_e.sum));
        chk("c_out", 32'(c_out), 32'(mon_e.c_out));
        chk("ovf", 32'(ovf), 32'(mon_e.ovf));
        chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("busy_at_done", 32'(busy), 32'd0);
        last_sum = sum;
      end
    end else if (busy) begin
      chk("sum_hold", 32'(sum), 32'(last_sum));
    end
  end

  // Called at a negedge while the DUT is IDLE or DONE; returns one cycle later.
  task automatic issue(input bit s, input logic [W-1:0] x, input logic [W-1:0] y, input bit ci);
    exp_t e;
    e = model(s, x, y, ci);
    e.cyc = cyc + N + 1;
    sb.push_back(e);
    sub = s; a = x; b = y; c_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(1'b0, 16'h1234, 16'h4321, 1'b0);
    chk("busy_cycle1", 32'(busy), 32'd1);
    wait_done(); @(negedge clk);
    issue(1'b0, 16'hFFFF, 16'h0001, 1'b0); wait_done(); @(negedge clk);
    issue(1'b0, 16'h00FF, 16'h0001, 1'b1); wait_done(); @(negedge clk);
    issue(1'b0, 16'h7FFF, 16'h0001, 1'b0); wait_done(); @(negedge clk);
    issue(1'b1, 16'h8000, 16'h0001, 1'b0); wait_done(); @(negedge clk);
    issue(1'b1, 16'h0005, 16'h0007, 1'b1); wait_done(); @(negedge clk);

    // Start during RUN must be ignored; then back-to-back issue in the done cycle.
    issue(1'b0, 16'h1111, 16'h2222, 1'b0);
    start = 1'b1; a = 16'hAAAA; b = 16'h5555;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    issue(1'b0, 16'h0F0F, 16'h00F1, 1'b0);
    wait_done(); @(negedge clk);

    // Reset in the second RUN cycle aborts the operation.
    issue(1'b0, 16'h3333, 16'h1111, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_sum", 32'(sum), 32'd0);
    chk("rst_mid_c_out", 32'(c_out), 32'd0);
    chk("rst_mid_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    issue(1'b0, 16'h0001, 16'h0002, 1'b0); wait_done();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      issue(1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
      wait_done();
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised multi-cycle successor to the team's 4-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock through a DIGIT-bit ripple chain.
- A carry flop links each digit to the next, and a start/busy/done handshake controls each operation.
- Used where a full-width combinational carry chain would limit clock rate or area; also adds signed-overflow reporting.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle. Must be at least 1 and must divide WIDTH. NDIG = WIDTH/DIGIT.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only when not busy.
- sub  in  1  0 = A+B+c_in; 1 = A-B (computed as A + ~B + 1, c_in ignored).
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- c_in  in  1  carry-in for add; sampled with start.
- busy  out  1  high while digits are being processed.
- done  out  1  one-cycle pulse when sum/c_out/ovf become valid.
- sum  out  WIDTH  result register.
- c_out  out  1  carry out of MSB. For sub, 1 means no borrow (A >= B unsigned).
- ovf  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high on port reset; it wins over every other input.
- Reset values: state IDLE, busy 0, done 0, sum 0, c_out 0, ovf 0, digit counter 0, carry flop 0.
- States: IDLE, RUN, DONE. State, busy, done, sum, c_out and ovf are all registered.
- Accepting start:
  - start=1 in IDLE or DONE latches a, b^{WIDTH{sub}} and carry = sub ? 1 : c_in. Counter is cleared. Next state is RUN.
  - start is ignored in RUN. Operands changing during RUN have no effect.
- RUN, each cycle:
  - Digit k = counter, bits [k*DIGIT +: DIGIT], goes through the ripple chain with the carry flop.
  - The result digit is written into an internal partial register and the carry flop updates.
  - The carry into the top bit is captured on the last digit for ovf.
  - The counter increments. After digit NDIG-1 the next state is DONE.
- Latency: start high in cycle 0 gives busy high in cycles 1..NDIG and done high in cycle NDIG+1 (busy low then). With the defaults, done arrives in cycle 5.
- Result update: on entering DONE, sum, c_out and ovf load together. They hold their previous values throughout RUN and hold the new values until the next completion.
- DONE lasts exactly one cycle. It returns to IDLE, or to RUN if start=1 in that cycle (back-to-back issue, no bubble).
- NDIG=1 is legal: one RUN cycle, done in cycle 2.
- Arithmetic is modulo 2^WIDTH. Nothing saturates.
- Reset mid-RUN aborts the operation. No done pulse is produced and all outputs return to reset values.

Decomposition:
- Shared package holds:
  - localparam NDIG.
  - CNT_W = max(1, $clog2(NDIG)).
  - Enumerated state type {IDLE, RUN, DONE}.
- One sub-module, digit_rca: a purely combinational DIGIT-bit ripple chain built from the existing full-adder cell. Its outputs are the digit sum, the carry out, and the carry into its MSB (needed for ovf).
- Top level holds the FSM, counter, operand/partial registers and the carry flop.

Test Plan (WIDTH=16, DIGIT=4):
- Add, sub=0, a=0x1234, b=0x4321, c_in=0 -> busy cycles 1-4; done in cycle 5; sum=0x5555, c_out=0, ovf=0.
- Carry chain across all digits: a=0xFFFF, b=0x0001 -> sum=0x0000, c_out=1, ovf=0. Then a=0x00FF, b=0x0001, c_in=1 -> sum=0x0101, c_out=0.
- Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, c_out=0, ovf=1. Then sub with a=0x8000, b=0x0001 -> sum=0x7FFF, c_out=1, ovf=1.
- Subtract with borrow: sub=1, a=0x0005, b=0x0007, c_in=1 (ignored) -> sum=0xFFFE, c_out=0, ovf=0.
- Handshake:
  - A second start with different operands during cycles 1-4 is ignored; the first result is reported.
  - start held in the done cycle launches the next operation; its done comes 5 cycles later.
  - sum holds its old value while busy.
- Reset in cycle 2 of RUN -> no done pulse, all outputs 0. A following start with a=0x0001, b=0x0002 gives sum=0x0003 with done 5 cycles later.
